// File: rtl/bicubic_upsample_pipe_pkg.sv
`default_nettype none
// ============================================================================
// bicubic_upsample_pipe_pkg : coefficient tables, mode encodings and
// accumulator-width helpers shared by the x4 upsampler pipeline.
// Revision 1.0
// ============================================================================
package bicubic_upsample_pipe_pkg;

   localparam int FRAC_BITS_DEF = 7;

   typedef enum logic {
      MODE_BICUBIC  = 1'b0,
      MODE_BILINEAR = 1'b1
   } mode_e;

   // W[phase][tap]; every phase sums to 128 so flat regions pass unchanged.
   localparam int BICUBIC_TAB [4][4] = '{
      '{ 0, 128,   0,  0},
      '{-9, 111,  29, -3},
      '{-8,  72,  72, -8},
      '{-3,  29, 111, -9}
   };

   localparam int BILINEAR_TAB [4][4] = '{
      '{0, 128,  0, 0},
      '{0,  96, 32, 0},
      '{0,  64, 64, 0},
      '{0,  32, 96, 0}
   };

   function automatic int coef_of(input logic mode, input logic [1:0] phase,
                                  input logic [1:0] tap);
      return (mode == MODE_BILINEAR) ? BILINEAR_TAB[phase][tap]
                                     : BICUBIC_TAB[phase][tap];
   endfunction

   function automatic int vert_width(input int cw, input int coefw);
      return cw + coefw + 2;
   endfunction

   function automatic int horz_width(input int cw, input int coefw);
      return cw + 2 * coefw + 4;
   endfunction

endpackage
`default_nettype wire

// File: rtl/bicubic_upsample_pipe_if.sv
`default_nettype none
// ============================================================================
// bicubic_upsample_pipe_if : window-in / block-out valid-ready bundle.
// Revision 1.0
// ============================================================================
interface bicubic_upsample_pipe_if #(
   parameter int CHANNEL_WIDTH = 8,
   parameter int CHANNELS      = 3
);
   localparam int DW = CHANNELS * 16 * CHANNEL_WIDTH;

   logic          bf_req_valid;
   logic          bcci_req_ready;
   logic          bf_req_mode;
   logic [DW-1:0] bf_req_win;
   logic          bcci_rsp_valid;
   logic          bf_rsp_ready;
   logic [DW-1:0] bcci_rsp_data;

   modport master (
      output bf_req_valid, bf_req_mode, bf_req_win, bf_rsp_ready,
      input  bcci_req_ready, bcci_rsp_valid, bcci_rsp_data
   );

   modport slave (
      input  bf_req_valid, bf_req_mode, bf_req_win, bf_rsp_ready,
      output bcci_req_ready, bcci_rsp_valid, bcci_rsp_data
   );
endinterface
`default_nettype wire

// File: rtl/bicubic_upsample_pipe_dot4.sv
`default_nettype none
// ============================================================================
// bicubic_dot4 : combinational signed 4-tap multiply-accumulate.
// Revision 1.0
// ============================================================================
module bicubic_dot4
   import bicubic_upsample_pipe_pkg::*;
#(
   parameter int IN_W   = 9,
   parameter int COEF_W = 9,
   parameter int OUT_W  = 19
) (
   input  logic [3:0][IN_W-1:0]   a_i,
   input  logic [3:0][COEF_W-1:0] w_i,
   output logic signed [OUT_W-1:0] sum_o
);
   logic signed [OUT_W-1:0] prod [4];

   for (genvar t = 0; t < 4; t++) begin : g_tap
      assign prod[t] = OUT_W'(signed'(a_i[t])) * OUT_W'(signed'(w_i[t]));
   end

   assign sum_o = prod[0] + prod[1] + prod[2] + prod[3];
endmodule
`default_nettype wire

// File: rtl/bicubic_upsample_pipe.sv
`default_nettype none
// ============================================================================
// bicubic_upsample_pipe : 3-stage x4 bicubic/bilinear upsampler with
// valid/ready backpressure. BICUBIC_UPSAMPLE_PERF_CNT_EN adds perf counters.
// Revision 1.0
// ============================================================================
module bicubic_upsample_pipe
   import bicubic_upsample_pipe_pkg::*;
#(
   parameter int CHANNEL_WIDTH = 8,
   parameter int CHANNELS      = 3,
   parameter int COEF_WIDTH    = 9,
   parameter int FRAC_BITS     = FRAC_BITS_DEF
) (
   input  logic clk,
   input  logic rst,
`ifdef BICUBIC_UPSAMPLE_PERF_CNT_EN
   output logic [31:0] perf_blk_cnt,
   output logic [31:0] perf_stall_cnt,
`endif
   bicubic_upsample_pipe_if.slave pipe_if
);
   localparam int DW    = CHANNELS * 16 * CHANNEL_WIDTH;
   localparam int VW    = vert_width(CHANNEL_WIDTH, COEF_WIDTH);
   localparam int AW    = horz_width(CHANNEL_WIDTH, COEF_WIDTH);
   localparam int SHIFT = 2 * FRAC_BITS;
   localparam logic signed [AW-1:0] ROUND_C = AW'(2 ** (SHIFT - 1));
   localparam logic signed [AW-1:0] PIX_MAX = AW'(2 ** CHANNEL_WIDTH - 1);

   logic s1_valid_q, s2_valid_q, s3_valid_q;
   logic s1_en, s2_en, s3_en;
   logic s1_mode_q;

   logic [CHANNELS-1:0][3:0][3:0][VW-1:0] v_d, s1_v_q;
   logic [CHANNELS-1:0][3:0][3:0][AW-1:0] a_d, s2_a_q;
   logic [DW-1:0]                         o_d, s3_o_q;

   logic [3:0][3:0][COEF_WIDTH-1:0] w_vert, w_horz;

   // Each stage loads when empty or when its successor is loading.
   assign s3_en = ~s3_valid_q | pipe_if.bf_rsp_ready;
   assign s2_en = ~s2_valid_q | s3_en;
   assign s1_en = ~s1_valid_q | s2_en;

   assign pipe_if.bcci_req_ready = s1_en;
   assign pipe_if.bcci_rsp_valid = s3_valid_q;
   assign pipe_if.bcci_rsp_data  = s3_o_q;

   // The horizontal pass reads the mode that entered with its own beat.
   for (genvar p = 0; p < 4; p++) begin : g_coef_ph
      for (genvar t = 0; t < 4; t++) begin : g_coef_tap
         assign w_vert[p][t] = COEF_WIDTH'(coef_of(pipe_if.bf_req_mode, 2'(p), 2'(t)));
         assign w_horz[p][t] = COEF_WIDTH'(coef_of(s1_mode_q, 2'(p), 2'(t)));
      end
   end

   for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
      for (genvar c = 0; c < 4; c++) begin : g_vcol
         logic [3:0][CHANNEL_WIDTH:0] col;
         for (genvar r = 0; r < 4; r++) begin : g_vrow
            assign col[r] = {1'b0,
               pipe_if.bf_req_win[((k * 16) + r * 4 + c) * CHANNEL_WIDTH +: CHANNEL_WIDTH]};
         end
         for (genvar i = 0; i < 4; i++) begin : g_vph
            bicubic_dot4 #(
               .IN_W   (CHANNEL_WIDTH + 1),
               .COEF_W (COEF_WIDTH),
               .OUT_W  (VW)
            ) u_vert (
               .a_i   (col),
               .w_i   (w_vert[i]),
               .sum_o (v_d[k][i][c])
            );
         end
      end

      for (genvar i = 0; i < 4; i++) begin : g_hrow
         for (genvar j = 0; j < 4; j++) begin : g_hph
            logic signed [AW-1:0] acc, rnd;

            bicubic_dot4 #(
               .IN_W   (VW),
               .COEF_W (COEF_WIDTH),
               .OUT_W  (AW)
            ) u_horz (
               .a_i   (s1_v_q[k][i]),
               .w_i   (w_horz[j]),
               .sum_o (a_d[k][i][j])
            );

            assign acc = signed'(s2_a_q[k][i][j]);
            assign rnd = (acc + ROUND_C) >>> SHIFT;
            assign o_d[((k * 16) + i * 4 + j) * CHANNEL_WIDTH +: CHANNEL_WIDTH] =
               rnd[AW-1]       ? '0 :
               (rnd > PIX_MAX) ? '1 : rnd[CHANNEL_WIDTH-1:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         s3_valid_q <= 1'b0;
      end else begin
         if (s1_en) s1_valid_q <= pipe_if.bf_req_valid;
         if (s2_en) s2_valid_q <= s1_valid_q;
         if (s3_en) s3_valid_q <= s2_valid_q;
      end
   end

   // Payload registers carry no reset; validity lives only in the flags above.
   always_ff @(posedge clk) begin
      if (s1_en) begin
         s1_v_q    <= v_d;
         s1_mode_q <= pipe_if.bf_req_mode;
      end
      if (s2_en) s2_a_q <= a_d;
      if (s3_en) s3_o_q <= o_d;
   end

`ifdef BICUBIC_UPSAMPLE_PERF_CNT_EN
   logic [31:0] blk_cnt_q, stall_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         blk_cnt_q   <= '0;
         stall_cnt_q <= '0;
      end else begin
         if (s3_valid_q & pipe_if.bf_rsp_ready & ~&blk_cnt_q)
            blk_cnt_q <= blk_cnt_q + 32'd1;
         if (s3_valid_q & ~pipe_if.bf_rsp_ready & ~&stall_cnt_q)
            stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign perf_blk_cnt   = blk_cnt_q;
   assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule
`default_nettype wire
